// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 8;
  localparam logic [7:0] DEF_RST_PAT = 8'b0000_1011;
  localparam int         DEF_RST_LEN = 4;

  // Width needed to hold a length in the range 0..pat_w inclusive.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Configuration record sized for the default pattern width; wider builds
  // declare the same layout locally from their own parameters.
  typedef struct packed {
    logic [DEF_PAT_W-1:0]            pat;
    logic [len_width(DEF_PAT_W)-1:0] len;
    logic                            ovl;
`ifdef SEQ_DET_MASK_EN
    logic [DEF_PAT_W-1:0]            mask;
`endif
  } cfg_def_t;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register with a saturating fill counter; clr empties both,
// fill_rst restarts the fill count while still shifting the new bit in.
module seq_det_hist #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr,
  input  logic             fill_rst,
  input  logic             data,
  output logic [PAT_W-1:0] hist_nxt,
  output logic [LEN_W-1:0] fill_inc
);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  assign hist_nxt = {hist[PAT_W-2:0], data};
  assign fill_inc = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      fill <= fill_rst ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Optional SEQ_DET_MASK_EN adds a per-bit don't-care mask to the compare.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               RST_LEN = DEF_RST_LEN,
  parameter int               LEN_W   = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask;
`endif
  } cfg_t;

  cfg_t             cfg;
  logic             shift;
  logic             match;
  logic             fill_rst;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] cmp_mask;

  // A config load discards the bit presented in the same cycle.
  assign shift    = in_valid & ~cfg_load;
  assign fill_rst = match & ~cfg.ovl;

  seq_det_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .clr      (cfg_load),
    .fill_rst (fill_rst),
    .data     (in),
    .hist_nxt (hist_nxt),
    .fill_inc (fill_inc)
  );

  // NOTE: the mask is given a full default before the loop so no bit of it
  // can be left unassigned and infer a latch.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(cfg.len));
    end
  end

`ifdef SEQ_DET_MASK_EN
  assign cmp_mask = len_mask & cfg.mask;
`else
  assign cmp_mask = len_mask;
`endif

  assign match = shift && (cfg.len != '0) && (fill_inc >= cfg.len) &&
                 (((hist_nxt ^ cfg.pat) & cmp_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg.pat  <= RST_PAT;
      cfg.len  <= LEN_W'(RST_LEN);
      cfg.ovl  <= 1'b1;
`ifdef SEQ_DET_MASK_EN
      cfg.mask <= '1;
`endif
      cfg_err  <= 1'b0;
    end else if (cfg_load) begin
      cfg.pat  <= cfg_pat;
      cfg.ovl  <= cfg_ovl;
`ifdef SEQ_DET_MASK_EN
      cfg.mask <= cfg_mask;
`endif
      cfg.len  <= (int'(cfg_len) > PAT_W) ? LEN_W'(PAT_W) : cfg_len;
      cfg_err  <= (cfg_len == '0) || (int'(cfg_len) > PAT_W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      out <= match;
      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: a bit-list model checked every cycle,
// plus literal expectations on pulse counts, counter values and cfg_err.
module tb_seq_det_prog;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = 4;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovl = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cnt_clr   (cnt_clr),
    .out       (out),
    .match_cnt (match_cnt),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of accepted bits, count of bits since the last fresh start.
  bit         m_bits[$];
  int         m_nb;
  int         m_len;
  logic [7:0] m_pat;
  bit         m_ovl;
  int         m_cnt;
  bit         m_out;
  bit         m_err;

  always @(posedge clk or negedge rst) begin
    bit hit;
    hit = 1'b0;
    if (!rst) begin
      m_bits.delete();
      m_nb = 0; m_len = 4; m_pat = 8'b0000_1011; m_ovl = 1'b1;
      m_cnt = 0; m_out = 1'b0; m_err = 1'b0;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pat;
        m_ovl = cfg_ovl;
        m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
        m_err = (cfg_len == 0) || (int'(cfg_len) > PAT_W);
        m_bits.delete();
        m_nb = 0;
      end else if (in_valid) begin
        m_bits.push_back(in);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        m_nb++;
        if (m_len > 0 && m_nb >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_nb = 0;
      end
      m_out = hit;
      if (cnt_clr) m_cnt = 0;
      else if (hit && m_cnt < CMAX) m_cnt++;
    end
  end

  always @(negedge clk) begin
    check("out", int'(out), int'(m_out));
    check("match_cnt", int'(match_cnt), m_cnt);
    check("cfg_err", int'(cfg_err), int'(m_err));
    if (out) pulses++;
  end

  task automatic step(input bit v, input bit b, input bit clr);
    @(posedge clk); #1;
    in_valid = v; in = b; cnt_clr = clr; cfg_load = 1'b0;
  endtask

  // Load also presents a valid '1' that must be discarded, and clears the counter.
  task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl);
    @(posedge clk); #1;
    cfg_load = 1'b1; cfg_pat = pat; cfg_len = LEN_W'(len); cfg_ovl = ovl;
    in_valid = 1'b1; in = 1'b1; cnt_clr = 1'b1;
  endtask

  task automatic send(input bit bits[]);
    foreach (bits[i]) step(1'b1, bits[i], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    int exp_cnt [6] = '{1, 2, 3, 3, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", int'(out), 0);
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_err", int'(cfg_err), 0);
    rst = 1'b1;

    // Reset pattern 1011, overlapping.
    base = pulses;
    send('{1, 0, 1, 1, 0, 1, 1});
    check("ovl_pulses", pulses - base, 2);
    check("ovl_cnt", int'(match_cnt), 2);

    // Non-overlapping.
    do_cfg(8'b1011, 4, 1'b0);
    base = pulses;
    send('{1, 0, 1, 1, 0, 1, 1});
    check("novl_pulses", pulses - base, 1);
    check("novl_cnt", int'(match_cnt), 1);

    // Gapped valid.
    do_cfg(8'b1011, 4, 1'b0);
    base = pulses;
    foreach (exp_cnt[i]) begin end
    step(1, 1, 0); step(0, 0, 0); step(1, 0, 0); step(0, 1, 0);
    step(1, 1, 0); step(0, 0, 0); step(1, 1, 0); step(0, 0, 0);
    step(0, 0, 0);
    check("gap_pulses", pulses - base, 1);

    // Reprogram to 110 after a stream of 101.
    send('{1, 0, 1, 1, 0, 1, 1, 0, 1, 1});
    do_cfg(8'b110, 3, 1'b1);
    base = pulses;
    send('{1, 1, 0});
    check("len3_pulses", pulses - base, 1);

    // len=0: idle detector, sticky error.
    do_cfg(8'h00, 0, 1'b1);
    base = pulses;
    send('{0, 0, 0, 0, 0});
    check("len0_err", int'(cfg_err), 1);
    check("len0_pulses", pulses - base, 0);

    // len=9 clamps to 8.
    do_cfg(8'h0F, 9, 1'b1);
    base = pulses;
    send('{0, 0, 0, 0, 1, 1, 1, 1});
    check("len9_err", int'(cfg_err), 1);
    check("len9_pulses", pulses - base, 1);

    do_cfg(8'b1011, 4, 1'b1);
    step(0, 0, 0);
    check("legal_err", int'(cfg_err), 0);

    // len=1 non-overlapping, saturation, and clear on the 5th match.
    do_cfg(8'b1, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, k == 4);
      if (k > 0) check("sat_cnt", int'(match_cnt), exp_cnt[k-1]);
      if (k == 5) check("clr_out", int'(out), 1);
    end
    step(0, 0, 0);
    check("sat_cnt_last", int'(match_cnt), exp_cnt[5]);

    // Reset mid-stream discards partial history.
    do_cfg(8'b1011, 4, 1'b1);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    base = pulses;
    send('{1});
    check("rst_pulses", pulses - base, 0);
    send('{1, 0, 1, 1});
    check("post_rst_pulses", pulses - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
